mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4:1 datapath multiplexer. Four requesters compete for a single downstream consumer. The block grants one requester at a time, drives the mux select `s`, and presents the selected word with a valid/ready handshake. Each grant is capped at `MAX_BURST` beats. It sits between the requester ports and the shared consumer, and it owns the select lines of the 16-bit mux datapath.

---
 rtl/mux4_ctrl_pkg.sv | 31 +++
 rtl/mux4_rr_arbiter_if.sv | 38 +++
 rtl/mux4_rr_arbiter_mux4.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 91 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mux4_ctrl_pkg.sv
// mux4_ctrl_pkg
// Shared definitions for the round-robin 4:1 mux arbiter: requester count,
// select width, FSM state encoding and the round-robin pick function.
// No ports; imported by the interface and the arbiter top.
package mux4_ctrl_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Rotate the request vector so the search starts at ptr, then take the
   // first set bit. Walking the offsets from high to low lets the smallest
   // offset overwrite the result last, so it wins. With no request set the
   // result is ptr, which callers ignore because they gate on |req.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [SEL_W-1:0]   ptr);
      logic [SEL_W-1:0] idx;
      rr_pick = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ptr + SEL_W'(k);
         if (req[idx]) begin
            rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if
// Bundles the requester side and the consumer side of the shared mux.
//   req       : per-requester request, held while in<i> carries valid data
//   in0..in3  : requester data words
//   out_ready : consumer accepts a word this cycle
//   gnt       : one-hot grant, zero when idle
//   s         : registered mux select
//   out       : selected data word
//   out_valid : word on out is valid
// Modports: master drives requests/data/ready, slave is the arbiter.
interface mux4_rr_arbiter_if
   import mux4_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
);

   logic [NUM_REQ-1:0] req;
   logic [WIDTH-1:0]   in0;
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic [WIDTH-1:0]   in3;
   logic               out_ready;
   logic [NUM_REQ-1:0] gnt;
   logic [SEL_W-1:0]   s;
   logic [WIDTH-1:0]   out;
   logic               out_valid;

   modport master (
      output req, in0, in1, in2, in3, out_ready,
      input  gnt, s, out, out_valid
   );

   modport slave (
      input  req, in0, in1, in2, in3, out_ready,
      output gnt, s, out, out_valid
   );

endinterface

// File: rtl/mux4_rr_arbiter_mux4.sv
// mux4
// Single-bit 4:1 multiplexer cell, replicated per bit of the datapath.
//   s       : select
//   a,b,c,d : inputs for select 0..3
//   y       : selected bit
module mux4 (
   input  logic [1:0] s,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   output logic       y
);

   // Plain combinational select; every branch assigns y.
   always_comb begin
      case (s)
         2'd0:    y = a;
         2'd1:    y = b;
         2'd2:    y = c;
         default: y = d;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter and sequencer for a shared 4:1 datapath mux. Grants one
// requester at a time for at most MAX_BURST beats, drives the registered
// select, and presents the selected word with a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux4_rr_arbiter_if (req, in0..in3, out_ready in;
//           gnt, s, out, out_valid out)
module mux4_rr_arbiter
   import mux4_ctrl_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mux4_rr_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   state_t             state;
   logic [NUM_REQ-1:0] gnt_q;
   logic [SEL_W-1:0]   s_q;
   logic [SEL_W-1:0]   ptr;
   logic [CNT_W-1:0]   cnt;

   logic [SEL_W-1:0]   pick;
   logic               owner_req;
   logic               xfer;
   logic               release_now;

   // Valid comes only from the state and the owner's request, never from
   // out_ready, so there is no combinational ready-to-valid path. A burst
   // ends either on its last beat or as soon as the owner withdraws.
   assign pick        = rr_pick(bus.req, ptr);
   assign owner_req   = bus.req[s_q];
   assign bus.out_valid = (state == ST_BUSY) && owner_req;
   assign xfer        = bus.out_valid && bus.out_ready;
   assign release_now = !owner_req || (xfer && (cnt == CNT_W'(MAX_BURST - 1)));

   assign bus.gnt = gnt_q;
   assign bus.s   = s_q;

   // Grant FSM. The select is held across release so that out keeps showing
   // the last owner's word while idle; the pointer moves one past the
   // released owner so it gets lowest priority at the next pick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         gnt_q <= '0;
         s_q   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|bus.req) begin
                  s_q   <= pick;
                  gnt_q <= NUM_REQ'(1) << pick;
                  cnt   <= '0;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (release_now) begin
                  state <= ST_IDLE;
                  gnt_q <= '0;
                  ptr   <= s_q + SEL_W'(1);
                  cnt   <= '0;
               end else if (xfer) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   // Bit-sliced datapath built from the shared mux4 cell.
   for (genvar b = 0; b < WIDTH; b++) begin : g_slice
      mux4 u_mux (
         .s (s_q),
         .a (bus.in0[b]),
         .b (bus.in1[b]),
         .c (bus.in2[b]),
         .d (bus.in3[b]),
         .y (bus.out[b])
      );
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
// Directed bench for mux4_rr_arbiter (WIDTH=16, MAX_BURST=4). Each scenario
// queues the beats it expects; a negedge monitor pops one entry per accepted
// beat and compares owner, select and data. Cycle-level checks cover grant
// timing, idle gaps, backpressure and the asynchronous reset.
module tb_mux4_rr_arbiter;

   localparam logic [15:0] D0 = 16'h1000;
   localparam logic [15:0] D1 = 16'h2111;
   localparam logic [15:0] D2 = 16'hA5A5;
   localparam logic [15:0] D3 = 16'h3C3C;

   typedef struct packed {
      logic [1:0]  idx;
      logic [15:0] data;
   } beat_t;

   logic  clk;
   logic  rst_n;
   int    total;
   int    bad;
   beat_t expQ[$];

   mux4_rr_arbiter_if #(.WIDTH(16)) bus ();

   mux4_rr_arbiter #(.WIDTH(16), .MAX_BURST(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] dataFor(input logic [1:0] idx);
      case (idx)
         2'd0:    return D0;
         2'd1:    return D1;
         2'd2:    return D2;
         default: return D3;
      endcase
   endfunction

   task automatic pushBeats(input logic [1:0] idx, input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back('{idx: idx, data: dataFor(idx)});
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] reqV, input logic readyV);
      bus.req       = reqV;
      bus.out_ready = readyV;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Scoreboard monitor: every accepted beat must match the queue head.
   always @(negedge clk) begin
      beat_t e;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL beat: unexpected beat s=%0d out=%h at %0t", bus.s, bus.out, $time);
         end else begin
            e = expQ.pop_front();
            if (bus.s !== e.idx || bus.out !== e.data || bus.gnt !== (4'b0001 << e.idx)) begin
               bad++;
               $display("[TB] FAIL beat: got s=%0d gnt=%b out=%h expected s=%0d out=%h at %0t",
                        bus.s, bus.gnt, bus.out, e.idx, e.data, $time);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      total++;
      bad++;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int seq[5];
      seq = '{0, 1, 2, 3, 0};
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.in0 = D0;
      bus.in1 = D1;
      bus.in2 = D2;
      bus.in3 = D3;
      applyStimulus(4'b1111, 1'b1);

      // Reset held with all requests asserted.
      stepCycle();
      stepCycle();
      checkOutput("reset gnt", 32'(bus.gnt), 32'h0);
      checkOutput("reset s", 32'(bus.s), 32'h0);
      checkOutput("reset valid", 32'(bus.out_valid), 32'h0);

      // Fairness: continuous requests rotate 0,1,2,3,0 with one idle cycle.
      for (int g = 0; g < 5; g++) pushBeats(2'(seq[g]), 4);
      rst_n = 1'b1;
      stepCycle();
      for (int g = 0; g < 5; g++) begin
         checkOutput("fair gnt", 32'(bus.gnt), 32'h1 << seq[g]);
         repeat (4) stepCycle();
         checkOutput("fair idle gnt", 32'(bus.gnt), 32'h0);
         checkOutput("fair idle valid", 32'(bus.out_valid), 32'h0);
         if (g == 4) applyStimulus(4'b0000, 1'b1);
         stepCycle();
      end

      // Single requester 2: burst, one idle cycle, regrant.
      applyStimulus(4'b0100, 1'b1);
      pushBeats(2'd2, 8);
      stepCycle();
      checkOutput("single gnt", 32'(bus.gnt), 32'h4);
      checkOutput("single s", 32'(bus.s), 32'h2);
      repeat (4) stepCycle();
      checkOutput("single idle gnt", 32'(bus.gnt), 32'h0);
      checkOutput("single idle valid", 32'(bus.out_valid), 32'h0);
      stepCycle();
      checkOutput("single regrant", 32'(bus.gnt), 32'h4);
      repeat (4) stepCycle();
      applyStimulus(4'b0000, 1'b1);
      stepCycle();

      // Backpressure on owner 1 after its second beat.
      applyStimulus(4'b0010, 1'b1);
      pushBeats(2'd1, 4);
      stepCycle();
      checkOutput("bp gnt", 32'(bus.gnt), 32'h2);
      stepCycle();
      stepCycle();
      applyStimulus(4'b0010, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checkOutput("bp hold gnt", 32'(bus.gnt), 32'h2);
         checkOutput("bp hold s", 32'(bus.s), 32'h1);
         checkOutput("bp hold out", 32'(bus.out), 32'(D1));
         checkOutput("bp hold cnt", 32'(dut.cnt), 32'h2);
         stepCycle();
      end
      applyStimulus(4'b0010, 1'b1);
      checkOutput("bp resume gnt", 32'(bus.gnt), 32'h2);
      stepCycle();
      stepCycle();
      checkOutput("bp done gnt", 32'(bus.gnt), 32'h0);
      applyStimulus(4'b0000, 1'b1);
      stepCycle();

      // Early release: owner 0 withdraws after two beats, then 3 is served.
      applyStimulus(4'b0001, 1'b1);
      pushBeats(2'd0, 2);
      pushBeats(2'd3, 2);
      stepCycle();
      checkOutput("early gnt", 32'(bus.gnt), 32'h1);
      applyStimulus(4'b1001, 1'b1);
      stepCycle();
      stepCycle();
      applyStimulus(4'b1000, 1'b1);
      checkOutput("early drop valid", 32'(bus.out_valid), 32'h0);
      stepCycle();
      checkOutput("early idle gnt", 32'(bus.gnt), 32'h0);
      checkOutput("early idle valid", 32'(bus.out_valid), 32'h0);
      stepCycle();
      checkOutput("early next gnt", 32'(bus.gnt), 32'h8);

      // Asynchronous reset between edges during owner 3's burst.
      stepCycle();
      stepCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("areset gnt", 32'(bus.gnt), 32'h0);
      checkOutput("areset valid", 32'(bus.out_valid), 32'h0);
      checkOutput("areset s", 32'(bus.s), 32'h0);
      applyStimulus(4'b1010, 1'b1);
      rst_n = 1'b1;
      pushBeats(2'd1, 4);
      stepCycle();
      checkOutput("areset regrant", 32'(bus.gnt), 32'h2);
      repeat (4) stepCycle();
      checkOutput("final idle gnt", 32'(bus.gnt), 32'h0);
      checkOutput("final idle valid", 32'(bus.out_valid), 32'h0);
      checkOutput("final idle out", 32'(bus.out), 32'(D1));
      applyStimulus(4'b0000, 1'b1);
      stepCycle();
      stepCycle();

      checkOutput("queue drained", 32'(expQ.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
